hilo_issue_ctrl: RTL and testbench

- Pipeline-side initiator for the multi-cycle HI/LO multiply/divide unit.
- Accepts HI/LO-class operations from the EX stage and drives the unit's `start`/`op`/operand inputs.
- Holds operands and op stable for the unit's full run.
- Interlocks the pipeline on HI/LO hazards, returns MFHI/MFLO data, and supervises completion with a watchdog.

---
 rtl/hilo_issue_ctrl.sv | 157 +++++++++++++++
 tb/tb_hilo_issue_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_issue_ctrl.sv
// hilo_issue_ctrl: EX-stage initiator for the multi-cycle HI/LO multiply/divide unit.
// Issues MD/MT operations, interlocks HI/LO hazards, returns MF data and watches for a hung unit.
module hilo_issue_ctrl #(
  parameter int unsigned LAT  = 34,
  parameter int unsigned WDOG = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        pipe_stall,
  output logic [31:0] rdata,
  output logic        md_start,
  output logic [4:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        md_done,
  output logic        busy,
  output logic        err
);

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_MFHI = 5'b01000;
  localparam logic [4:0] OP_MTHI = 5'b01001;
  localparam logic [4:0] OP_MFLO = 5'b01010;
  localparam logic [4:0] OP_MTLO = 5'b01011;
  localparam logic [5:0] LAT_C   = 6'(LAT);
  localparam logic [5:0] WDOG_M1 = 6'(WDOG - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [4:0]  h_op_q;
  logic [31:0] h_a_q, h_b_q;

  logic is_md_s, is_mt_s, is_mf_s, issue_s;

  assign is_md_s = (req_op[4:2] == 3'b011);
  assign is_mt_s = (req_op == OP_MTHI) || (req_op == OP_MTLO);
  assign is_mf_s = (req_op == OP_MFHI) || (req_op == OP_MFLO);
  assign issue_s = (state_q == ST_IDLE) && req_valid && is_md_s;

  assign rdata = (req_op == OP_MFLO) ? md_lo : md_hi;
  assign busy  = busy_q;
  assign err   = err_q;

  // Unit-facing outputs and pipeline interlock
  always_comb begin
    pipe_stall = 1'b0;
    md_start   = 1'b0;
    md_op      = h_op_q;
    md_a       = h_a_q;
    md_b       = h_b_q;
    case (state_q)
      ST_IDLE: begin
        md_start = issue_s;
        md_a     = req_a;
        md_b     = req_b;
        if (req_valid && (is_md_s || is_mt_s)) begin
          md_op = req_op;
        end else begin
          md_op = OP_NONE;
        end
      end
      ST_BUSY: begin
        // The MF that lands in the done cycle sees the final HI/LO and may proceed.
        pipe_stall = req_valid && (is_md_s || is_mt_s || (is_mf_s && !md_done));
      end
      ST_DRAIN: begin
        pipe_stall = req_valid && (is_md_s || is_mt_s || is_mf_s);
      end
      default: begin
        pipe_stall = req_valid && (is_md_s || is_mt_s || is_mf_s);
      end
    endcase
  end

  // Next-state, watchdog counter and sticky error
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_s) begin
          state_d = ST_BUSY;
          cnt_d   = 6'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          state_d = ST_IDLE;
        end else if (cnt_q == WDOG_M1) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DRAIN: begin
        if (md_done || (cnt_q == 6'd0)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
        // An unknown state is treated like reset: let any unit run finish first.
        state_d = ST_DRAIN;
        cnt_d   = LAT_C;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control state register; reset enters DRAIN so an interrupted unit run can finish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DRAIN;
      cnt_q   <= LAT_C;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Operand hold registers: deliberately outside reset so the unit keeps stable inputs
  always_ff @(posedge clk) begin
    if (issue_s) begin
      h_op_q <= req_op;
      h_a_q  <= req_a;
      h_b_q  <= req_b;
    end else begin
      h_op_q <= h_op_q;
      h_a_q  <= h_a_q;
      h_b_q  <= h_b_q;
    end
  end

endmodule

// File: tb/tb_hilo_issue_ctrl.sv
// Directed bench for hilo_issue_ctrl with a behavioural model of the HI/LO unit.
module tb_hilo_issue_ctrl;

  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_MFHI  = 5'b01000;
  localparam logic [4:0] OP_MTHI  = 5'b01001;
  localparam logic [4:0] OP_MFLO  = 5'b01010;
  localparam logic [4:0] OP_MTLO  = 5'b01011;
  localparam logic [4:0] OP_MULT  = 5'b01100;
  localparam logic [4:0] OP_MULTU = 5'b01101;
  localparam logic [4:0] OP_DIV   = 5'b01110;
  localparam logic [4:0] OP_DIVU  = 5'b01111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [4:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        pipe_stall;
  logic [31:0] rdata;
  logic        md_start;
  logic [4:0]  md_op;
  logic [31:0] md_a, md_b, md_hi, md_lo;
  logic        md_done, busy, err;

  int tests = 0;
  int fails = 0;
  int starts = 0;

  logic        suppress   = 1'b0;
  logic        extra_done = 1'b0;
  logic        u_run      = 1'b0;
  logic [5:0]  u_cnt      = 6'd0;
  logic [4:0]  u_op       = 5'd0;
  logic [31:0] u_a        = 32'd0;
  logic [31:0] u_b        = 32'd0;
  logic [31:0] u_hi       = 32'h0000_0000;
  logic [31:0] u_lo       = 32'hDEAD_BEEF;
  logic [31:0] p_hi       = 32'd0;
  logic [31:0] p_lo       = 32'd0;
  logic        unstable   = 1'b0;

  always #5 clk = ~clk;

  hilo_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .pipe_stall (pipe_stall),
    .rdata      (rdata),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_a       (md_a),
    .md_b       (md_b),
    .md_hi      (md_hi),
    .md_lo      (md_lo),
    .md_done    (md_done),
    .busy       (busy),
    .err        (err)
  );

  function automatic logic [63:0] calc(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 64'd0;
    case (op)
      OP_MULT:  r = 64'(sa * sb);
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV:   if (b != 32'd0) r = {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  if (b != 32'd0) r = {a % b, a / b};
      default:  r = 64'd0;
    endcase
    return r;
  endfunction

  // Unit model: done in the LAT-th cycle after the start edge, HI/LO final in that cycle
  always @(posedge clk) begin
    if (md_start === 1'b1) begin
      u_run <= 1'b1;
      u_cnt <= 6'd33;
      u_op  <= md_op;
      u_a   <= md_a;
      u_b   <= md_b;
      {p_hi, p_lo} <= calc(md_op, md_a, md_b);
    end else if (u_run) begin
      if (md_op !== u_op || md_a !== u_a || md_b !== u_b) unstable <= 1'b1;
      if (u_cnt == 6'd1 && !suppress) begin
        u_hi <= p_hi;
        u_lo <= p_lo;
      end
      if (u_cnt != 6'd0) u_cnt <= u_cnt - 6'd1;
      else u_run <= 1'b0;
    end else if (md_op === OP_MTHI) begin
      u_hi <= md_a;
    end else if (md_op === OP_MTLO) begin
      u_lo <= md_a;
    end
  end

  assign md_hi   = u_hi;
  assign md_lo   = u_lo;
  assign md_done = (u_run && u_cnt == 6'd0 && !suppress) || extra_done;

  always @(posedge clk) if (md_start === 1'b1) starts <= starts + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  initial begin
    int n;
    int bad;
    int s0;
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    #2 rst_n = 1'b0;

    // Reset state
    drive(1'b1, OP_MFLO, 32'd0, 32'd0);
    smp();
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_err", err, 1'b0);
    chk1("rst_start", md_start, 1'b0);
    chk1("rst_stall_mf", pipe_stall, 1'b1);
    drive(1'b1, OP_ADD, 32'd0, 32'd0);
    #1;
    chk1("rst_stall_other", pipe_stall, 1'b0);
    chk("rst_rdata_hi", rdata, 32'h0000_0000);
    nxt();
    nxt();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      nxt();
      n++;
    end
    chk("drain_len", 32'(n), 32'd35);
    smp();
    chk("idle_neutral_op", 32'(md_op), 32'd0);
    nxt();

    // MULT 7 * -3, MFLO right behind it
    s0 = starts;
    drive(1'b1, OP_MULT, 32'd7, 32'hFFFF_FFFD);
    smp();
    chk1("mult_start", md_start, 1'b1);
    chk1("mult_nostall", pipe_stall, 1'b0);
    chk("mult_op", 32'(md_op), 32'(OP_MULT));
    nxt();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0);
    n = 0;
    smp();
    while (pipe_stall === 1'b1 && n < 60) begin
      n++;
      nxt();
      smp();
    end
    chk("mult_mf_stall_len", 32'(n), 32'd33);
    chk("mult_mflo", rdata, 32'hFFFF_FFEB);
    chk1("mult_busy_in_done", busy, 1'b1);
    nxt();
    drive(1'b1, OP_MFHI, 32'd0, 32'd0);
    smp();
    chk1("mult_mfhi_nostall", pipe_stall, 1'b0);
    chk("mult_mfhi", rdata, 32'hFFFF_FFFF);
    chk1("mult_idle", busy, 1'b0);
    chk("mult_one_start", 32'(starts - s0), 32'd1);
    nxt();

    // DIV -7 / 2 with operand hold check
    drive(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    smp();
    chk1("div_start", md_start, 1'b1);
    nxt();
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    n = 0;
    bad = 0;
    smp();
    while (busy === 1'b1 && n < 60) begin
      if (md_op !== OP_DIV || md_a !== 32'hFFFF_FFF9 || md_b !== 32'd2) bad++;
      n++;
      nxt();
      smp();
    end
    chk("div_hold", 32'(bad), 32'd0);
    chk("div_busy_len", 32'(n), 32'd34);
    nxt();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0);
    smp();
    chk1("div_mflo_nostall", pipe_stall, 1'b0);
    chk("div_mflo", rdata, 32'hFFFF_FFFD);
    nxt();
    drive(1'b1, OP_MFHI, 32'd0, 32'd0);
    smp();
    chk("div_mfhi", rdata, 32'hFFFF_FFFF);
    nxt();

    // MTHI / MTLO then read back
    drive(1'b1, OP_MTHI, 32'h0000_1234, 32'd0);
    smp();
    chk("mthi_op", 32'(md_op), 32'(OP_MTHI));
    chk("mthi_a", md_a, 32'h0000_1234);
    chk1("mthi_nostart", md_start, 1'b0);
    chk1("mthi_nostall", pipe_stall, 1'b0);
    nxt();
    drive(1'b1, OP_MFHI, 32'd0, 32'd0);
    smp();
    chk("mthi_readback", rdata, 32'h0000_1234);
    chk1("mthi_mf_nostall", pipe_stall, 1'b0);
    nxt();
    drive(1'b1, OP_MTLO, 32'h0000_CAFE, 32'd0);
    nxt();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0);
    smp();
    chk("mtlo_readback", rdata, 32'h0000_CAFE);
    nxt();

    // DIVU 100/7 then MFLO
    drive(1'b1, OP_DIVU, 32'd100, 32'd7);
    nxt();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0);
    n = 0;
    smp();
    while (pipe_stall === 1'b1 && n < 60) begin
      n++;
      nxt();
      smp();
    end
    chk("divu_mflo", rdata, 32'd14);
    nxt();

    // DIVU 100/7 followed immediately by MULTU 3*5
    drive(1'b1, OP_DIVU, 32'd100, 32'd7);
    nxt();
    drive(1'b1, OP_MULTU, 32'd3, 32'd5);
    n = 0;
    smp();
    while (pipe_stall === 1'b1 && n < 60) begin
      n++;
      nxt();
      smp();
    end
    chk("md_md_stall_len", 32'(n), 32'd34);
    chk1("multu_issue_start", md_start, 1'b1);
    chk("multu_issue_op", 32'(md_op), 32'(OP_MULTU));
    nxt();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0);
    n = 0;
    smp();
    while (pipe_stall === 1'b1 && n < 60) begin
      n++;
      nxt();
      smp();
    end
    chk("multu_mflo", rdata, 32'd15);
    nxt();

    // Reset in BUSY cycle 10: drain against held operands
    drive(1'b1, OP_MULT, 32'd6, 32'd7);
    nxt();
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 9; i++) nxt();
    rst_n = 1'b0;
    drive(1'b1, OP_MFLO, 32'd0, 32'd0);
    smp();
    chk1("rst_busy_mid", busy, 1'b1);
    chk("rst_hold_op", 32'(md_op), 32'(OP_MULT));
    chk("rst_hold_a", md_a, 32'd6);
    chk("rst_hold_b", md_b, 32'd7);
    chk1("rst_mid_stall", pipe_stall, 1'b1);
    nxt();
    nxt();
    rst_n = 1'b1;
    n = 0;
    smp();
    while (pipe_stall === 1'b1 && n < 60) begin
      n++;
      nxt();
      smp();
    end
    chk("drain_stall_len", 32'(n), 32'd23);
    chk("drain_mflo", rdata, 32'd42);
    chk1("drain_idle", busy, 1'b0);
    nxt();

    // Watchdog: unit never signals done
    suppress = 1'b1;
    drive(1'b1, OP_MULTU, 32'd2, 32'd2);
    nxt();
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      nxt();
      n++;
    end
    chk("wdog_busy_len", 32'(n), 32'd40);
    chk1("wdog_err", err, 1'b1);
    for (int i = 0; i < 3; i++) nxt();
    extra_done = 1'b1;
    nxt();
    extra_done = 1'b0;
    smp();
    chk1("idle_done_ignored", busy, 1'b0);
    chk1("wdog_err_sticky", err, 1'b1);
    nxt();
    rst_n = 1'b0;
    smp();
    chk1("wdog_err_cleared", err, 1'b0);
    chk1("wdog_rst_busy", busy, 1'b1);
    nxt();
    rst_n = 1'b1;
    suppress = 1'b0;
    chk1("unit_inputs_stable", unstable, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
